// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake between the EX-stage redirect controller and fetch.
//   redir_valid : controller -> fetch, redirect request
//   redir_pc    : controller -> fetch, new fetch PC (stable while redir_valid)
//   redir_ready : fetch -> controller, redirect accepted
// master = redirect controller, slave = fetch unit.
interface branch_redirect_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  redir_valid;
  logic                  redir_ready;
  logic [DATA_WIDTH-1:0] redir_pc;

  modport master (
    output redir_valid,
    output redir_pc,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    output redir_ready
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer.
// Takes control-flow resolution from EX and issues a PC redirect to fetch over a
// valid/ready handshake. While the redirect is outstanding, it flushes IF/ID and stalls EX.
// After the handshake it keeps IF flushed for FLUSH_CYCLES cycles to drain in-flight
// fetches. Taken targets that are not word aligned raise a one-cycle misalign_exc pulse
// instead of redirecting. Saturating counters track taken and not-taken outcomes.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   ex_*                 EX-stage resolution (valid, branch, jump, take, pc, target)
//   redir                redirect handshake to fetch (master side)
//   flush_if, flush_id   kill IF / ID instructions
//   stall_ex             hold EX and upstream
//   misalign_exc, exc_pc misaligned-target exception pulse and faulting PC
//   clr_cnt              synchronous clear of the statistics counters
//   taken_cnt, ntaken_cnt saturating statistics
module branch_redirect_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic                  ex_jump,
  input  logic                  ex_take,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_target,
  branch_redirect_ctrl_if.master redir,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  stall_ex,
  output logic                  misalign_exc,
  output logic [DATA_WIDTH-1:0] exc_pc,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  taken_cnt,
  output logic [CNT_WIDTH-1:0]  ntaken_cnt
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

  // Drain counter is loaded with FLUSH_CYCLES-1; only meaningful when FLUSH_CYCLES > 0.
  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [DATA_WIDTH-1:0] exc_pc_q, exc_pc_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  taken_q, taken_d;
  logic [CNT_WIDTH-1:0]  ntaken_q, ntaken_d;
  logic                  taken_inc, ntaken_inc;
  logic                  cf, aligned;

  assign cf      = ex_valid & (ex_branch | ex_jump);
  assign aligned = (ex_target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_pc_d = redir_pc_q;
    exc_pc_d   = exc_pc_q;
    misalign_d = 1'b0;
    taken_inc  = 1'b0;
    ntaken_inc = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cf) begin
          if (ex_take) begin
            if (aligned) begin
              redir_pc_d = ex_target;
              taken_inc  = 1'b1;
              state_d    = StRedirect;
            end else begin
              misalign_d = 1'b1;
              exc_pc_d   = ex_pc;
            end
          end else if (ex_jump) begin
            // A not-taken jump cannot happen; counting it as taken keeps the stats sane.
            taken_inc = 1'b1;
          end else begin
            ntaken_inc = 1'b1;
          end
        end
      end
      StRedirect: begin
        if (redir.redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StFlush;
            cnt_d   = FlushInit;
          end
        end
      end
      StFlush: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    if (clr_cnt) begin
      taken_d  = '0;
      ntaken_d = '0;
    end else begin
      taken_d  = (taken_inc && (taken_q != '1)) ? taken_q + CNT_WIDTH'(1) : taken_q;
      ntaken_d = (ntaken_inc && (ntaken_q != '1)) ? ntaken_q + CNT_WIDTH'(1) : ntaken_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      redir_pc_q <= '0;
      exc_pc_q   <= '0;
      misalign_q <= 1'b0;
      taken_q    <= '0;
      ntaken_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
      exc_pc_q   <= exc_pc_d;
      misalign_q <= misalign_d;
      taken_q    <= taken_d;
      ntaken_q   <= ntaken_d;
    end
  end

  // All outputs decode registered state only; no ex_* input reaches them combinationally.
  assign redir.redir_valid = (state_q == StRedirect);
  assign redir.redir_pc    = redir_pc_q;
  assign flush_if          = (state_q == StRedirect) | (state_q == StFlush);
  assign flush_id          = (state_q == StRedirect);
  assign stall_ex          = (state_q == StRedirect) | (state_q == StFlush);
  assign misalign_exc      = misalign_q;
  assign exc_pc            = exc_pc_q;
  assign taken_cnt         = taken_q;
  assign ntaken_cnt        = ntaken_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vectors, a behavioural model checked on every
// falling edge, and literal expectations at key points of each scenario.
module tb_branch_redirect_ctrl;
  localparam int unsigned DW   = 32;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid, ex_branch, ex_jump, ex_take, clr_cnt;
  logic [DW-1:0] ex_pc, ex_target;
  logic          flush_if, flush_id, stall_ex, misalign_exc;
  logic [DW-1:0] exc_pc;
  logic [CW-1:0] taken_cnt, ntaken_cnt;

  branch_redirect_ctrl_if #(.DATA_WIDTH(DW)) rif ();

  branch_redirect_ctrl #(
    .DATA_WIDTH  (DW),
    .FLUSH_CYCLES(FC),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_jump     (ex_jump),
    .ex_take     (ex_take),
    .ex_pc       (ex_pc),
    .ex_target   (ex_target),
    .redir       (rif),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .stall_ex    (stall_ex),
    .misalign_exc(misalign_exc),
    .exc_pc      (exc_pc),
    .clr_cnt     (clr_cnt),
    .taken_cnt   (taken_cnt),
    .ntaken_cnt  (ntaken_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "waiting for fetch" flag plus number of drain cycles still to go.
  bit            m_wait;
  int            m_drain;
  logic [DW-1:0] m_pc, m_exc;
  bit            m_mis;
  int            m_taken, m_ntaken;

  always @(posedge clk or negedge rst_n) begin
    int inc_t, inc_n;
    if (!rst_n) begin
      m_wait = 0; m_drain = 0; m_pc = '0; m_exc = '0; m_mis = 0;
      m_taken = 0; m_ntaken = 0;
    end else begin
      inc_t = 0;
      inc_n = 0;
      m_mis = 0;
      if (m_wait) begin
        if (rif.redir_ready) begin
          m_wait  = 0;
          m_drain = FC;
        end
      end else if (m_drain > 0) begin
        m_drain--;
      end else if (ex_valid && (ex_branch || ex_jump)) begin
        if (!ex_take) begin
          if (ex_jump) inc_t = 1;
          else         inc_n = 1;
        end else if (ex_target[1:0] != 2'b00) begin
          m_mis = 1;
          m_exc = ex_pc;
        end else begin
          m_wait = 1;
          m_pc   = ex_target;
          inc_t  = 1;
        end
      end
      if (clr_cnt) begin
        m_taken  = 0;
        m_ntaken = 0;
      end else begin
        m_taken  = (m_taken + inc_t > CMAX) ? CMAX : m_taken + inc_t;
        m_ntaken = (m_ntaken + inc_n > CMAX) ? CMAX : m_ntaken + inc_n;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_redir_valid", {31'd0, rif.redir_valid}, {31'd0, m_wait});
      if (m_wait) chk("m_redir_pc", rif.redir_pc, m_pc);
      chk("m_flush_if", {31'd0, flush_if}, {31'd0, (m_wait || m_drain > 0)});
      chk("m_flush_id", {31'd0, flush_id}, {31'd0, m_wait});
      chk("m_stall_ex", {31'd0, stall_ex}, {31'd0, (m_wait || m_drain > 0)});
      chk("m_misalign", {31'd0, misalign_exc}, {31'd0, m_mis});
      chk("m_exc_pc", exc_pc, m_exc);
      chk("m_taken_cnt", {28'd0, taken_cnt}, m_taken);
      chk("m_ntaken_cnt", {28'd0, ntaken_cnt}, m_ntaken);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one EX instruction for a single cycle; returns 1 time unit after the accept edge.
  task automatic issue(input logic b, input logic j, input logic t,
                       input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
    ex_valid = 1'b1; ex_branch = b; ex_jump = j; ex_take = t; ex_pc = pc; ex_target = tgt;
    step();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_take = 1'b0;
  endtask

  initial begin
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_take = 0; clr_cnt = 0;
    ex_pc = '0; ex_target = '0;
    rif.redir_ready = 1'b1;
    repeat (2) step();
    chk("rst_redir_valid", {31'd0, rif.redir_valid}, 32'd0);
    chk("rst_redir_pc", rif.redir_pc, 32'd0);
    chk("rst_stall_ex", {31'd0, stall_ex}, 32'd0);
    chk("rst_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // BEQ taken, ready already high
    issue(1, 0, 1, 32'h3c, 32'h100);
    chk("beq_valid_n1", {31'd0, rif.redir_valid}, 32'd1);
    chk("beq_pc_n1", rif.redir_pc, 32'h100);
    chk("beq_flush_id_n1", {31'd0, flush_id}, 32'd1);
    step();
    chk("beq_valid_n2", {31'd0, rif.redir_valid}, 32'd0);
    chk("beq_flush_if_n2", {31'd0, flush_if}, 32'd1);
    chk("beq_flush_id_n2", {31'd0, flush_id}, 32'd0);
    step();
    chk("beq_flush_if_n3", {31'd0, flush_if}, 32'd1);
    step();
    chk("beq_stall_n4", {31'd0, stall_ex}, 32'd0);
    chk("beq_taken_cnt", {28'd0, taken_cnt}, 32'd1);

    // JAL taken, fetch holds ready low for 5 cycles
    rif.redir_ready = 1'b0;
    issue(0, 1, 1, 32'h80, 32'h200);
    for (int i = 0; i < 5; i++) begin
      chk("jal_valid_hold", {31'd0, rif.redir_valid}, 32'd1);
      chk("jal_pc_hold", rif.redir_pc, 32'h200);
      chk("jal_stall_hold", {31'd0, stall_ex}, 32'd1);
      step();
    end
    chk("jal_valid_n6", {31'd0, rif.redir_valid}, 32'd1);
    rif.redir_ready = 1'b1;
    step();
    chk("jal_valid_n7", {31'd0, rif.redir_valid}, 32'd0);
    repeat (2) step();
    chk("jal_stall_done", {31'd0, stall_ex}, 32'd0);
    chk("jal_taken_cnt", {28'd0, taken_cnt}, 32'd2);

    // BNE not taken
    issue(1, 0, 0, 32'h90, 32'h300);
    chk("bne_valid", {31'd0, rif.redir_valid}, 32'd0);
    chk("bne_stall", {31'd0, stall_ex}, 32'd0);
    chk("bne_ntaken_cnt", {28'd0, ntaken_cnt}, 32'd1);

    // Not-taken jump counts as taken, no redirect
    issue(0, 1, 0, 32'h94, 32'h400);
    chk("jnt_valid", {31'd0, rif.redir_valid}, 32'd0);
    chk("jnt_taken_cnt", {28'd0, taken_cnt}, 32'd3);

    // Misaligned taken target
    issue(1, 0, 1, 32'h40, 32'h102);
    chk("mis_pulse", {31'd0, misalign_exc}, 32'd1);
    chk("mis_exc_pc", exc_pc, 32'h40);
    chk("mis_valid", {31'd0, rif.redir_valid}, 32'd0);
    chk("mis_taken_cnt", {28'd0, taken_cnt}, 32'd3);
    step();
    chk("mis_pulse_end", {31'd0, misalign_exc}, 32'd0);
    chk("mis_exc_pc_held", exc_pc, 32'h40);

    // 16 taken branches saturate the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 1, 32'h400 + 32'(i) * 32'h10, 32'h1000 + 32'(i) * 32'h4);
      repeat (3) step();
    end
    chk("sat_taken_cnt", {28'd0, taken_cnt}, 32'hF);

    // Clear wins over a concurrent taken increment
    clr_cnt = 1'b1;
    issue(1, 0, 1, 32'h500, 32'h2000);
    clr_cnt = 1'b0;
    chk("clr_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    chk("clr_ntaken_cnt", {28'd0, ntaken_cnt}, 32'd0);
    chk("clr_redir_valid", {31'd0, rif.redir_valid}, 32'd1);
    repeat (3) step();

    // Asynchronous reset while a redirect is outstanding
    rif.redir_ready = 1'b0;
    issue(1, 0, 1, 32'h600, 32'h3000);
    chk("pre_rst_valid", {31'd0, rif.redir_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rif.redir_valid}, 32'd0);
    chk("arst_flush_if", {31'd0, flush_if}, 32'd0);
    chk("arst_stall", {31'd0, stall_ex}, 32'd0);
    chk("arst_redir_pc", rif.redir_pc, 32'd0);
    chk("arst_exc_pc", exc_pc, 32'd0);
    chk("arst_taken_cnt", {28'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    rif.redir_ready = 1'b1;
    step();
    issue(1, 0, 1, 32'h700, 32'h800);
    chk("post_rst_valid", {31'd0, rif.redir_valid}, 32'd1);
    chk("post_rst_pc", rif.redir_pc, 32'h800);
    chk("post_rst_taken", {28'd0, taken_cnt}, 32'd1);
    repeat (3) step();
    chk("post_rst_idle", {31'd0, stall_ex}, 32'd0);

    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
